shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_acc.sv | 66 ++++++
 rtl/shift_add_mult.sv | 123 ++++++++++++
 tb/tb_shift_add_mult.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller state
// encoding and the bit-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int STATE_W = 2;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_acc.sv
// 2N+1-bit accumulator for the shift-add multiplier.
// ACC[2N:N] is the partial sum (with carry/sign bit), ACC[N-1:0] holds the
// multiplier bits that shift out LSB first. Controls are prioritised
// Load > Ad > Sh. Optional signed mode: SHIFT_ADD_MULT_SIGNED_EN.
module mult_acc
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_load,
  input  logic           i_ad,
  input  logic           i_sh,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
  input  logic           i_sub,
`endif
  input  logic [N-1:0]   i_mcand,
  input  logic [N-1:0]   i_mplier,
  output logic [2*N-1:0] o_acc_lo
);

  logic [2*N:0] r_acc;
  logic [N-1:0] r_mcand;
  logic [N:0]   w_sum;
  logic [2*N:0] w_shifted;

  // Next partial sum and shifted accumulator for the current mode.
  always_comb begin
    w_sum     = r_acc[2*N:N];
    w_shifted = r_acc;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    // Mcand is sign-extended; the final multiplier bit carries negative
    // weight, so its partial product is subtracted.
    if (i_sub) begin
      w_sum = r_acc[2*N:N] - {r_mcand[N-1], r_mcand};
    end else begin
      w_sum = r_acc[2*N:N] + {r_mcand[N-1], r_mcand};
    end
    w_shifted = {r_acc[2*N], r_acc[2*N:1]};
`else
    w_sum     = r_acc[2*N:N] + {1'b0, r_mcand};
    w_shifted = {1'b0, r_acc[2*N:1]};
`endif
  end

  // Accumulator and multiplicand registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
    end else if (i_load) begin
      r_acc   <= {{(N+1){1'b0}}, i_mplier};
      r_mcand <= i_mcand;
    end else if (i_ad) begin
      if (r_acc[0]) begin
        r_acc[2*N:N] <= w_sum;
      end
    end else if (i_sh) begin
      r_acc <= w_shifted;
    end
  end

  assign o_acc_lo = r_acc[2*N-1:0];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: IDLE -> (ADD, SHIFT) x N -> FIN.
// Done pulses one cycle with Product, 2N+1 clocks after the accepting edge.
// Product holds until the next result. St is only sampled in IDLE.
// Optional two's-complement mode: define SHIFT_ADD_MULT_SIGNED_EN.
// Handshake: a request is accepted on a rising edge where St=1 and Busy=0;
// operands are captured on that edge and ignored afterwards until Done.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int DATA_LENGTH = 4
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic                     St,
  input  logic [DATA_LENGTH-1:0]   Mcand,
  input  logic [DATA_LENGTH-1:0]   Mplier,
  output logic                     Busy,
  output logic                     Done,
  output logic [2*DATA_LENGTH-1:0] Product,
  output logic [STATE_W-1:0]       o_dbg_state
);

  localparam int N  = DATA_LENGTH;
  localparam int CW = cnt_width(DATA_LENGTH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_load;
  logic            w_ad;
  logic            w_sh;
  logic            w_last;
  logic [2*N-1:0]  w_acc_lo;
  logic [2*N-1:0]  r_product;
  logic            r_done;

  assign w_last = (r_cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ad        = 1'b0;
    w_sh        = 1'b0;
    case (r_state)
      IDLE: begin
        if (St) begin
          w_load      = 1'b1;
          w_state_nxt = ADD;
        end
      end
      ADD: begin
        w_ad        = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_sh        = 1'b1;
        w_state_nxt = w_last ? FIN : ADD;
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counts completed shifts; cleared on load.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_sh) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result capture: Product and Done rise on the same edge leaving FIN.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == FIN);
      if (r_state == FIN) begin
        r_product <= w_acc_lo;
      end
    end
  end

  mult_acc #(
    .N (N)
  ) u_acc (
    .i_clk    (Clk),
    .i_rst_n  (rst),
    .i_load   (w_load),
    .i_ad     (w_ad),
    .i_sh     (w_sh),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    .i_sub    (w_last),
`endif
    .i_mcand  (Mcand),
    .i_mplier (Mplier),
    .o_acc_lo (w_acc_lo)
  );

  assign Busy        = (r_state != IDLE);
  assign Done        = r_done;
  assign Product     = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_mult.sv
// Testbench for shift_add_mult (N=4). The reference model works at the
// transaction level: a request is taken when the unit is free, the result
// is the arithmetic product, and it appears a fixed number of edges later.
module tb_shift_add_mult;

  localparam int N   = 4;
  localparam int LAT = 2 * N + 1;

  logic           Clk = 1'b0;
  logic           rst;
  logic           St;
  logic [N-1:0]   Mcand;
  logic [N-1:0]   Mplier;
  logic           Busy;
  logic           Done;
  logic [2*N-1:0] Product;
  logic [1:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*N-1:0] exp_q[$];
  int             exp_edge_q[$];
  int             free_edge = 0;
  int             cur_a     = -100;
  logic [2*N-1:0] last_prod = '0;

  shift_add_mult #(
    .DATA_LENGTH (N)
  ) dut (
    .Clk         (Clk),
    .rst         (rst),
    .St          (St),
    .Mcand       (Mcand),
    .Mplier      (Mplier),
    .Busy        (Busy),
    .Done        (Done),
    .Product     (Product),
    .o_dbg_state (dbg_state)
  );

  // Clock and edge counter.
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'(a) * longint'(b);
`endif
    return p[2*N-1:0];
  endfunction

  // Driver: called at a falling edge; inputs are sampled on the next rising edge.
  task automatic drive(input bit st, input logic [N-1:0] a, input logic [N-1:0] b);
    St     = st;
    Mcand  = a;
    Mplier = b;
    if (st && rst && (cyc + 1 >= free_edge)) begin
      exp_q.push_back(model(a, b));
      exp_edge_q.push_back(cyc + 1 + LAT);
      cur_a     = cyc + 1;
      free_edge = cyc + 1 + LAT + 1;
    end
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, N'($urandom), N'($urandom));
  endtask

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
    drive(1'b1, a, b);
    idle(LAT + 1);
  endtask

  task automatic check_zero(input string tag);
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== '0) begin
      bad++;
      $display("FAIL %s busy=%b done=%b product=%h required 0/0/00", tag, Busy, Done, Product);
    end
  endtask

  task automatic reset_now();
    St  = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("reset_outputs");
    exp_q.delete();
    exp_edge_q.delete();
    cur_a     = -100;
    last_prod = '0;
    @(negedge Clk);
    @(negedge Clk);
    rst       = 1'b1;
    free_edge = cyc + 1;
  endtask

  // Monitor / scoreboard, sampling 1 time unit after each rising edge.
  initial begin
    logic [2*N-1:0] e;
    int             ed;
    logic           busy_exp;
    forever begin
      @(posedge Clk);
      #1;
      if (Done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done cyc=%0d product=%h required no done", cyc, Product);
        end else begin
          e  = exp_q.pop_front();
          ed = exp_edge_q.pop_front();
          total++;
          if (ed != cyc) begin
            bad++;
            $display("FAIL done_latency got edge %0d required edge %0d", cyc, ed);
          end
          total++;
          if (Product !== e) begin
            bad++;
            $display("FAIL product got %h required %h", Product, e);
          end
          last_prod = e;
        end
      end else begin
        if (exp_edge_q.size() > 0 && exp_edge_q[0] <= cyc) begin
          total++;
          bad++;
          $display("FAIL missing_done cyc=%0d required done with %h", cyc, exp_q[0]);
          void'(exp_q.pop_front());
          void'(exp_edge_q.pop_front());
        end
        total++;
        if (Product !== last_prod) begin
          bad++;
          $display("FAIL product_hold got %h required %h", Product, last_prod);
        end
      end
      busy_exp = (cur_a >= 0) && (cyc >= cur_a) && (cyc <= cur_a + 2 * N);
      total++;
      if (Busy !== busy_exp) begin
        bad++;
        $display("FAIL busy cyc=%0d got %b required %b", cyc, Busy, busy_exp);
      end
    end
  end

  // Stimulus.
  initial begin
    int k;
    int fe;
    logic [N-1:0] pa[3];
    logic [N-1:0] pb[3];
    rst    = 1'b0;
    St     = 1'b0;
    Mcand  = '0;
    Mplier = '0;
    #1;
    check_zero("power_on_reset");
    @(negedge Clk);
    @(negedge Clk);
    rst       = 1'b1;
    free_edge = cyc + 1;
    idle(2);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    op(4'h8, 4'h7);   // -8 * 7  = -56
    op(4'h8, 4'h8);   // -8 * -8 = 64
    op(4'h7, 4'hF);   //  7 * -1 = -7
`else
    op(4'd15, 4'd15);
    op(4'd13, 4'd0);
    op(4'd0,  4'd11);
    // second request while busy must be ignored
    drive(1'b1, 4'd3, 4'd5);
    idle(3);
    drive(1'b1, 4'd7, 4'd7);
    idle(LAT);
`endif

    // reset while the first SHIFT is in progress, then a fresh operation
    drive(1'b1, 4'd9, 4'd6);
    drive(1'b0, 4'd9, 4'd6);
    reset_now();
    op(4'd9, 4'd6);

    // St held high across three back-to-back operations
    pa[0] = 4'd2; pb[0] = 4'd3;
    pa[1] = 4'd4; pb[1] = 4'd5;
    pa[2] = 4'd6; pb[2] = 4'd7;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      fe = free_edge;
      if (cyc + 1 >= free_edge) drive(1'b1, pa[k], pb[k]);
      else                      drive(1'b1, N'($urandom), N'($urandom));
      if (free_edge != fe) k++;
    end
    idle(LAT + 2);

    // randomized traffic with spurious requests while busy
    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 2) == 0, N'($urandom), N'($urandom));
    end
    idle(LAT + 3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_results got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
